fm_spy_buffer: RTL and testbench
================================

// Module: fm_spy_buffer
// PURPOSE
//  Per-station spy buffer for fast monitoring. Consumes one fm_rt monitor stream (fm_data/fm_vld) into a
//  circular memory, freezes on request after N post-trigger samples, and serves the AXI-side SB_MEM
//  (data) and SB_META (metadata) read/write ports that fm_sb_pkg routes. One instance per entry of
//  total_sb (27).
// PARAMETERS
//  DATA_W      256  monitor word width (mon_dw_max); multiple of AXI_DW
//  AXI_DW      32   AXI data width
//  DEPTH_LOG2  9    log2 of entries held (512)
//  WPE         DATA_W/AXI_DW (8)  AXI words per entry, derived; WPE_LOG2 = 3
//  SB_AW       16   AXI address port width; used bits = DEPTH_LOG2+WPE_LOG2 (12)
// PORTS
//  spy_clock         in   1       single clock (monitor and AXI side)
//  rst               in   1       synchronous, active-high
//  fm_data           in   DATA_W  monitor data
//  fm_vld            in   1       monitor data valid
//  spy_enable        in   1       arm capture
//  freeze_req        in   1       trigger pulse
//  release_req       in   1       leave FROZEN, restart capture
//  post_trig         in   DEPTH_LOG2  samples still captured after trigger
//  axi_sb_addr       in   SB_AW   {entry, word}; word 0 = fm_data[AXI_DW-1:0]
//  axi_sb_enable     in   1       SB_MEM access strobe
//  axi_sb_wr_enable  in   1       SB_MEM write (else read)
//  axi_sb_wr_data    in   AXI_DW  SB_MEM write data
//  axi_sm_addr       in   SB_AW   SB_META register index
//  axi_sm_enable     in   1       SB_META access strobe
//  axi_sm_wr_enable  in   1       SB_META write
//  axi_sm_wr_data    in   AXI_DW  SB_META write data
//  axi_spy_data      out  AXI_DW  SB_MEM read data
//  axi_spy_meta_data out  AXI_DW  SB_META read data
//  frozen            out  1       state == FROZEN
//  pb_mode           in   2       playback mode (FM_SPY_PLAYBACK_EN only)
//  pb_data / pb_vld  out  DATA_W / 1  playback stream (FM_SPY_PLAYBACK_EN only)
// BEHAVIOUR
//  Reset: state IDLE; wr_ptr, count, post_cnt, overflow = 0; axi_spy_data, axi_spy_meta_data = 0;
//   frozen = 0; pb_vld = 0. Memory contents are not cleared.
//  Memory: WPE banks of AXI_DW x 2^DEPTH_LOG2; a capture writes all banks; AXI writes one bank.
//  FSM:
//   IDLE -> ARMED when spy_enable
//   ARMED: fm_vld writes mem[wr_ptr]; wr_ptr+1, wraps to 0; count saturates at 2^DEPTH_LOG2
//   ARMED -> POST on freeze_req (post_cnt = post_trig). If post_trig == 0 -> FROZEN directly;
//    a same-cycle fm_vld word is still written.
//   POST: each fm_vld writes and decrements post_cnt; the write with post_cnt == 1 -> FROZEN
//   FROZEN: no capture; trig_ptr = wr_ptr latched on entry
//   FROZEN -> ARMED on release_req (count = 0); -> IDLE if spy_enable = 0
//   ARMED/POST -> IDLE when spy_enable deasserts; count is kept
//   freeze_req in IDLE/FROZEN is ignored; release_req outside FROZEN is ignored
//  AXI SB_MEM:
//   read: data 1 cycle after axi_sb_enable & !wr_enable; output holds until next read
//   write: accepted only in IDLE/FROZEN. In ARMED/POST it is dropped and overflow+1
//    (saturating 16b).
//   Address bits >= DEPTH_LOG2+WPE_LOG2 are ignored.
//  AXI SB_META (1-cycle read latency):
//   0 trig_ptr; 1 count; 2 {state[1:0], wrapped}; 3 overflow; 4 wr_ptr
//   other indices read 0; write to index 3 clears overflow; other writes ignored
//  Simultaneous AXI read and capture to the same entry: read returns old data.
//  Reset mid-POST returns to IDLE in the next cycle with all counters cleared.
// CONFIGURATION
//  FM_SPY_PLAYBACK_EN defined:
//   in FROZEN with pb_mode == 2'b01, emit mem[trig_ptr - count .. trig_ptr - 1] on pb_data,
//    pb_vld 1 per cycle (2-cycle latency), then stop
//   pb_mode == 2'b10 loops that range continuously
//   leaving FROZEN or pb_mode == 0 stops within 1 cycle
//  Undefined: pb_data = 0, pb_vld = 0, pb_mode ignored; no playback logic synthesised.
// TESTING
//  1) rst; spy_enable; 10 fm_vld words D0..D9; freeze_req, post_trig = 0 -> frozen next cycle;
//     meta0 = 10, meta1 = 10.
//  2) 600 words, post_trig = 5 -> FROZEN after 5 more writes; meta1 = 512; wrapped = 1;
//     trig_ptr = 605 mod 512 = 93.
//  3) Read SB_MEM addr {entry 3, word 7} -> axi_spy_data = D3[255:224] exactly 1 cycle after enable.
//  4) SB_MEM write while ARMED -> memory unchanged, meta3 = 1; write meta3 -> meta3 = 0;
//     write in FROZEN -> readback matches.
//  5) freeze_req and fm_vld in same cycle, post_trig = 0 -> word stored, wr_ptr+1, FROZEN;
//     rst during POST -> IDLE, count = 0.
//  6) FM_SPY_PLAYBACK_EN, 4 stored words, pb_mode = 01 -> exactly 4 pb_vld cycles in capture order.

Source files
------------

// File: rtl/fm_spy_buffer.sv
// fm_spy_buffer: circular spy buffer for one monitor stream, frozen by trigger, read/written over AXI SB_MEM/SB_META
// Define FM_SPY_PLAYBACK_EN to add the frozen-buffer playback stream on pb_data/pb_vld.
module fm_spy_buffer #(
    parameter int DATA_W     = 256,
    parameter int AXI_DW     = 32,
    parameter int DEPTH_LOG2 = 9,
    parameter int SB_AW      = 16
) (
    input  logic              spy_clock,
    input  logic              rst,
    input  logic [DATA_W-1:0] fm_data,
    input  logic              fm_vld,
    input  logic              spy_enable,
    input  logic              freeze_req,
    input  logic              release_req,
    input  logic [DEPTH_LOG2-1:0] post_trig,
    input  logic [SB_AW-1:0]  axi_sb_addr,
    input  logic              axi_sb_enable,
    input  logic              axi_sb_wr_enable,
    input  logic [AXI_DW-1:0] axi_sb_wr_data,
    input  logic [SB_AW-1:0]  axi_sm_addr,
    input  logic              axi_sm_enable,
    input  logic              axi_sm_wr_enable,
    input  logic [AXI_DW-1:0] axi_sm_wr_data,
    output logic [AXI_DW-1:0] axi_spy_data,
    output logic [AXI_DW-1:0] axi_spy_meta_data,
    output logic              frozen,
    input  logic [1:0]        pb_mode,
    output logic [DATA_W-1:0] pb_data,
    output logic              pb_vld
);
    localparam int WPE      = DATA_W / AXI_DW;
    localparam int WPE_LOG2 = $clog2(WPE);
    localparam int DEPTH    = 1 << DEPTH_LOG2;
    localparam int UA       = DEPTH_LOG2 + WPE_LOG2;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ARMED  = 2'd1;
    localparam logic [1:0] POST   = 2'd2;
    localparam logic [1:0] FROZEN = 2'd3;

    logic [AXI_DW-1:0]     mem_q [WPE][DEPTH];
    logic [1:0]            state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, trig_ptr_q, trig_ptr_d, post_cnt_q, post_cnt_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [15:0]           ovf_q, ovf_d;
    logic [AXI_DW-1:0]     axi_spy_data_q, axi_spy_data_d, meta_q, meta_d, meta_val;
    logic                  capturing, capture, sb_rd, sb_wr, sb_wr_ok, sm_rd, ovf_clr, wrapped;
    logic [DEPTH_LOG2-1:0] sb_entry;
    logic [WPE_LOG2-1:0]   sb_word;
    logic                  unused_addr;

    assign capturing   = state_q == ARMED || state_q == POST;
    assign capture     = capturing && spy_enable && fm_vld;
    assign sb_rd       = axi_sb_enable && !axi_sb_wr_enable;
    assign sb_wr       = axi_sb_enable && axi_sb_wr_enable;
    assign sb_wr_ok    = sb_wr && !capturing;
    assign sm_rd       = axi_sm_enable && !axi_sm_wr_enable;
    assign ovf_clr     = axi_sm_enable && axi_sm_wr_enable && axi_sm_addr == SB_AW'(3);
    assign sb_entry    = axi_sb_addr[UA-1:WPE_LOG2];
    assign sb_word     = axi_sb_addr[WPE_LOG2-1:0];
    assign unused_addr = ^{axi_sb_addr[SB_AW-1:UA], axi_sm_wr_data};
    // Count saturates at DEPTH, so its top bit alone marks a fully overwritten buffer.
    assign wrapped     = count_q[DEPTH_LOG2];
    assign frozen      = state_q == FROZEN;

    always_comb begin
        state_d    = state_q;
        post_cnt_d = post_cnt_q;
        trig_ptr_d = trig_ptr_q;
        wr_ptr_d   = capture ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d    = capture && !wrapped ? count_q + 1'b1 : count_q;
        case (state_q)
            IDLE:   if (spy_enable) state_d = ARMED;
            ARMED:  if (!spy_enable) state_d = IDLE;
                    else if (freeze_req) begin
                        post_cnt_d = post_trig;
                        state_d    = post_trig == '0 ? FROZEN : POST;
                    end
            POST:   if (!spy_enable) state_d = IDLE;
                    else if (capture) begin
                        post_cnt_d = post_cnt_q - 1'b1;
                        state_d    = post_cnt_q == DEPTH_LOG2'(1) ? FROZEN : POST;
                    end
            default: if (!spy_enable) state_d = IDLE;
                    else if (release_req) begin
                        state_d = ARMED;
                        count_d = '0;
                    end
        endcase
        if (state_d == FROZEN && state_q != FROZEN) trig_ptr_d = wr_ptr_d;
    end

    assign ovf_d = ovf_clr ? '0 : sb_wr && capturing && ovf_q != '1 ? ovf_q + 1'b1 : ovf_q;
    assign meta_val = axi_sm_addr == SB_AW'(0) ? AXI_DW'(trig_ptr_q) :
                      axi_sm_addr == SB_AW'(1) ? AXI_DW'(count_q) :
                      axi_sm_addr == SB_AW'(2) ? AXI_DW'({state_q, wrapped}) :
                      axi_sm_addr == SB_AW'(3) ? AXI_DW'(ovf_q) :
                      axi_sm_addr == SB_AW'(4) ? AXI_DW'(wr_ptr_q) : '0;
    assign meta_d         = sm_rd ? meta_val : meta_q;
    assign axi_spy_data_d = sb_rd ? mem_q[sb_word][sb_entry] : axi_spy_data_q;

    always_ff @(posedge spy_clock) begin
        if (rst) begin
            state_q        <= IDLE;
            wr_ptr_q       <= '0;
            trig_ptr_q     <= '0;
            post_cnt_q     <= '0;
            count_q        <= '0;
            ovf_q          <= '0;
            axi_spy_data_q <= '0;
            meta_q         <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            trig_ptr_q     <= trig_ptr_d;
            post_cnt_q     <= post_cnt_d;
            count_q        <= count_d;
            ovf_q          <= ovf_d;
            axi_spy_data_q <= axi_spy_data_d;
            meta_q         <= meta_d;
        end
    end

    // Reads take the pre-edge contents, so a same-cycle capture never leaks into the read.
    always_ff @(posedge spy_clock) begin
        for (int b = 0; b < WPE; b++) begin
            if (capture) mem_q[b][wr_ptr_q] <= fm_data[b*AXI_DW +: AXI_DW];
            else if (sb_wr_ok && sb_word == WPE_LOG2'(b)) mem_q[b][sb_entry] <= axi_sb_wr_data;
        end
    end

    assign axi_spy_data      = axi_spy_data_q;
    assign axi_spy_meta_data = meta_q;

`ifdef FM_SPY_PLAYBACK_EN
    logic [DEPTH_LOG2:0]   pb_idx_q, pb_idx_d;
    logic [DEPTH_LOG2-1:0] pb_addr, pb_addr_q;
    logic [DATA_W-1:0]     pb_word, pb_data_q;
    logic                  pb_on, pb_iss, pb_last, pb_done_q, pb_done_d, pb_iss_q, pb_vld_q;

    assign pb_on     = state_q == FROZEN && pb_mode != 2'b00;
    assign pb_iss    = pb_on && count_q != '0 && (pb_mode == 2'b10 || (pb_mode == 2'b01 && !pb_done_q));
    assign pb_last   = pb_idx_q + 1'b1 == count_q;
    assign pb_addr   = trig_ptr_q - count_q[DEPTH_LOG2-1:0] + pb_idx_q[DEPTH_LOG2-1:0];
    assign pb_idx_d  = !pb_on ? '0 : pb_iss ? (pb_last ? '0 : pb_idx_q + 1'b1) : pb_idx_q;
    assign pb_done_d = pb_on && (pb_done_q || (pb_iss && pb_last));

    always_comb begin
        pb_word = '0;
        for (int b = 0; b < WPE; b++) pb_word[b*AXI_DW +: AXI_DW] = mem_q[b][pb_addr_q];
    end

    always_ff @(posedge spy_clock) begin
        if (rst) begin
            pb_idx_q  <= '0;
            pb_done_q <= 1'b0;
            pb_iss_q  <= 1'b0;
            pb_addr_q <= '0;
            pb_vld_q  <= 1'b0;
            pb_data_q <= '0;
        end else begin
            pb_idx_q  <= pb_idx_d;
            pb_done_q <= pb_done_d;
            pb_iss_q  <= pb_iss;
            pb_addr_q <= pb_addr;
            pb_vld_q  <= pb_iss_q && pb_on;
            pb_data_q <= pb_word;
        end
    end

    assign pb_data = pb_data_q;
    assign pb_vld  = pb_vld_q;
`else
    logic unused_pb;
    assign unused_pb = ^pb_mode;
    assign pb_data   = '0;
    assign pb_vld    = 1'b0;
`endif
endmodule

// File: tb/tb_fm_spy_buffer.sv
// tb_fm_spy_buffer: directed scenarios for fm_spy_buffer capture, freeze, AXI access and playback.
module tb_fm_spy_buffer;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] fm_data = '0;
    logic         fm_vld = 1'b0, spy_enable = 1'b0, freeze_req = 1'b0, release_req = 1'b0;
    logic [8:0]   post_trig = '0;
    logic [15:0]  axi_sb_addr = '0, axi_sm_addr = '0;
    logic         axi_sb_enable = 1'b0, axi_sb_wr_enable = 1'b0, axi_sm_enable = 1'b0, axi_sm_wr_enable = 1'b0;
    logic [31:0]  axi_sb_wr_data = '0, axi_sm_wr_data = '0;
    logic [31:0]  axi_spy_data, axi_spy_meta_data;
    logic         frozen, pb_vld;
    logic [1:0]   pb_mode = 2'b00;
    logic [255:0] pb_data;
    int           n_checks = 0, n_fail = 0;
    logic [31:0]  v;

    fm_spy_buffer dut (
        .spy_clock(clk), .rst(rst), .fm_data(fm_data), .fm_vld(fm_vld), .spy_enable(spy_enable),
        .freeze_req(freeze_req), .release_req(release_req), .post_trig(post_trig),
        .axi_sb_addr(axi_sb_addr), .axi_sb_enable(axi_sb_enable), .axi_sb_wr_enable(axi_sb_wr_enable),
        .axi_sb_wr_data(axi_sb_wr_data), .axi_sm_addr(axi_sm_addr), .axi_sm_enable(axi_sm_enable),
        .axi_sm_wr_enable(axi_sm_wr_enable), .axi_sm_wr_data(axi_sm_wr_data), .axi_spy_data(axi_spy_data),
        .axi_spy_meta_data(axi_spy_meta_data), .frozen(frozen), .pb_mode(pb_mode), .pb_data(pb_data),
        .pb_vld(pb_vld)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] wv(input int i, input int b);
        return 32'hA000_0000 | (32'(i) << 8) | 32'(b);
    endfunction

    function automatic logic [255:0] dval(input int i);
        logic [255:0] r;
        for (int b = 0; b < 8; b++) r[b*32 +: 32] = wv(i, b);
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        spy_enable = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic push(input int i);
        fm_data = dval(i);
        fm_vld = 1'b1;
        cyc();
        fm_vld = 1'b0;
    endtask

    task automatic freeze(input int pt);
        freeze_req = 1'b1;
        post_trig = 9'(pt);
        cyc();
        freeze_req = 1'b0;
    endtask

    task automatic release_buf();
        release_req = 1'b1;
        cyc();
        release_req = 1'b0;
    endtask

    task automatic meta_rd(input int idx, output logic [31:0] d);
        axi_sm_addr = 16'(idx);
        axi_sm_enable = 1'b1;
        axi_sm_wr_enable = 1'b0;
        cyc();
        axi_sm_enable = 1'b0;
        d = axi_spy_meta_data;
    endtask

    task automatic meta_wr(input int idx, input logic [31:0] d);
        axi_sm_addr = 16'(idx);
        axi_sm_wr_data = d;
        axi_sm_enable = 1'b1;
        axi_sm_wr_enable = 1'b1;
        cyc();
        axi_sm_enable = 1'b0;
        axi_sm_wr_enable = 1'b0;
    endtask

    task automatic sb_rd(input logic [15:0] addr, output logic [31:0] d);
        axi_sb_addr = addr;
        axi_sb_enable = 1'b1;
        axi_sb_wr_enable = 1'b0;
        cyc();
        axi_sb_enable = 1'b0;
        d = axi_spy_data;
    endtask

    task automatic sb_wr(input logic [15:0] addr, input logic [31:0] d);
        axi_sb_addr = addr;
        axi_sb_wr_data = d;
        axi_sb_enable = 1'b1;
        axi_sb_wr_enable = 1'b1;
        cyc();
        axi_sb_enable = 1'b0;
        axi_sb_wr_enable = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (frozen !== 1'b0) begin n_fail++; $display("FAIL reset_frozen got %b exp 0", frozen); end
        n_checks++; if (axi_spy_data !== 32'd0) begin n_fail++; $display("FAIL reset_spy_data got %h exp 0", axi_spy_data); end
        n_checks++; if (pb_vld !== 1'b0) begin n_fail++; $display("FAIL reset_pb_vld got %b exp 0", pb_vld); end
        meta_rd(2, v);
        n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL reset_meta2 got %h exp 0", v); end
        meta_rd(1, v);
        n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", v); end
    endtask

    task automatic test_capture_freeze();
        spy_enable = 1'b1;
        cyc();
        for (int i = 0; i < 10; i++) push(i);
        freeze(0);
        n_checks++; if (frozen !== 1'b1) begin n_fail++; $display("FAIL cap_frozen got %b exp 1", frozen); end
        meta_rd(0, v);
        n_checks++; if (v !== 32'd10) begin n_fail++; $display("FAIL cap_trig_ptr got %0d exp 10", v); end
        meta_rd(1, v);
        n_checks++; if (v !== 32'd10) begin n_fail++; $display("FAIL cap_count got %0d exp 10", v); end
        meta_rd(2, v);
        n_checks++; if (v !== 32'd6) begin n_fail++; $display("FAIL cap_meta2 got %h exp 6", v); end
        push(50);
        meta_rd(4, v);
        n_checks++; if (v !== 32'd10) begin n_fail++; $display("FAIL cap_frozen_no_capture wr_ptr got %0d exp 10", v); end
    endtask

    task automatic test_read_latency();
        axi_sb_addr = {4'd0, 9'd3, 3'd7};
        axi_sb_enable = 1'b1;
        #1;
        n_checks++; if (axi_spy_data !== 32'd0) begin n_fail++; $display("FAIL rd_early got %h exp 0", axi_spy_data); end
        cyc();
        axi_sb_enable = 1'b0;
        n_checks++; if (axi_spy_data !== wv(3, 7)) begin n_fail++; $display("FAIL rd_e3w7 got %h exp %h", axi_spy_data, wv(3, 7)); end
        cyc();
        n_checks++; if (axi_spy_data !== wv(3, 7)) begin n_fail++; $display("FAIL rd_hold got %h exp %h", axi_spy_data, wv(3, 7)); end
        sb_rd({4'd0, 9'd9, 3'd0}, v);
        n_checks++; if (v !== wv(9, 0)) begin n_fail++; $display("FAIL rd_e9w0 got %h exp %h", v, wv(9, 0)); end
    endtask

    task automatic test_wrap();
        do_reset();
        spy_enable = 1'b1;
        cyc();
        for (int i = 0; i < 600; i++) push(i);
        freeze(5);
        n_checks++; if (frozen !== 1'b0) begin n_fail++; $display("FAIL wrap_post_entry frozen got %b exp 0", frozen); end
        for (int i = 600; i < 604; i++) push(i);
        n_checks++; if (frozen !== 1'b0) begin n_fail++; $display("FAIL wrap_post4 frozen got %b exp 0", frozen); end
        push(604);
        n_checks++; if (frozen !== 1'b1) begin n_fail++; $display("FAIL wrap_post5 frozen got %b exp 1", frozen); end
        meta_rd(1, v);
        n_checks++; if (v !== 32'd512) begin n_fail++; $display("FAIL wrap_count got %0d exp 512", v); end
        meta_rd(2, v);
        n_checks++; if (v !== 32'd7) begin n_fail++; $display("FAIL wrap_meta2 got %h exp 7", v); end
        meta_rd(0, v);
        n_checks++; if (v !== 32'd93) begin n_fail++; $display("FAIL wrap_trig_ptr got %0d exp 93", v); end
        sb_rd({4'd0, 9'd92, 3'd2}, v);
        n_checks++; if (v !== wv(604, 2)) begin n_fail++; $display("FAIL wrap_e92 got %h exp %h", v, wv(604, 2)); end
        sb_rd({4'd0, 9'd0, 3'd5}, v);
        n_checks++; if (v !== wv(512, 5)) begin n_fail++; $display("FAIL wrap_e0 got %h exp %h", v, wv(512, 5)); end
    endtask

    task automatic test_axi_write();
        release_buf();
        meta_rd(1, v);
        n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL wr_release_count got %0d exp 0", v); end
        meta_rd(2, v);
        n_checks++; if (v !== 32'd2) begin n_fail++; $display("FAIL wr_armed_meta2 got %h exp 2", v); end
        sb_wr({4'd0, 9'd5, 3'd1}, 32'hDEAD_BEEF);
        sb_rd({4'd0, 9'd5, 3'd1}, v);
        n_checks++; if (v !== wv(517, 1)) begin n_fail++; $display("FAIL wr_armed_dropped got %h exp %h", v, wv(517, 1)); end
        meta_rd(3, v);
        n_checks++; if (v !== 32'd1) begin n_fail++; $display("FAIL wr_overflow got %0d exp 1", v); end
        meta_wr(3, 32'h0);
        meta_rd(3, v);
        n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL wr_overflow_clr got %0d exp 0", v); end
        freeze(0);
        sb_wr({4'd0, 9'd5, 3'd1}, 32'hDEAD_BEEF);
        sb_rd({4'd0, 9'd5, 3'd1}, v);
        n_checks++; if (v !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_frozen got %h exp deadbeef", v); end
        sb_rd({4'd0, 9'd5, 3'd0}, v);
        n_checks++; if (v !== wv(517, 0)) begin n_fail++; $display("FAIL wr_other_bank got %h exp %h", v, wv(517, 0)); end
        sb_rd({4'hF, 9'd5, 3'd1}, v);
        n_checks++; if (v !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_addr_upper got %h exp deadbeef", v); end
        meta_rd(7, v);
        n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL meta_idx7 got %h exp 0", v); end
    endtask

    task automatic test_same_cycle_and_reset();
        release_buf();
        fm_data = dval(700);
        fm_vld = 1'b1;
        freeze(0);
        fm_vld = 1'b0;
        n_checks++; if (frozen !== 1'b1) begin n_fail++; $display("FAIL same_frozen got %b exp 1", frozen); end
        meta_rd(4, v);
        n_checks++; if (v !== 32'd94) begin n_fail++; $display("FAIL same_wr_ptr got %0d exp 94", v); end
        meta_rd(1, v);
        n_checks++; if (v !== 32'd1) begin n_fail++; $display("FAIL same_count got %0d exp 1", v); end
        sb_rd({4'd0, 9'd93, 3'd0}, v);
        n_checks++; if (v !== wv(700, 0)) begin n_fail++; $display("FAIL same_stored got %h exp %h", v, wv(700, 0)); end
        release_buf();
        freeze(3);
        push(701);
        meta_rd(2, v);
        n_checks++; if (v !== 32'd4) begin n_fail++; $display("FAIL post_meta2 got %h exp 4", v); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        meta_rd(2, v);
        n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL rst_post_idle got %h exp 0", v); end
        meta_rd(1, v);
        n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL rst_post_count got %0d exp 0", v); end
        spy_enable = 1'b0;
        cyc();
        freeze(0);
        n_checks++; if (frozen !== 1'b0) begin n_fail++; $display("FAIL idle_freeze_ignored got %b exp 0", frozen); end
    endtask

    task automatic test_playback();
        int k;
        do_reset();
        spy_enable = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) push(800 + i);
        freeze(0);
        pb_mode = 2'b01;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            cyc();
`ifdef FM_SPY_PLAYBACK_EN
            if (pb_vld) begin
                n_checks++; if (pb_data !== dval(800 + k)) begin n_fail++; $display("FAIL pb_data%0d got %h exp %h", k, pb_data[31:0], wv(800 + k, 0)); end
                k++;
            end
`else
            n_checks++; if (pb_vld !== 1'b0 || pb_data !== '0) begin n_fail++; $display("FAIL pb_disabled vld %b data %h exp 0", pb_vld, pb_data[31:0]); end
`endif
        end
`ifdef FM_SPY_PLAYBACK_EN
        n_checks++; if (k != 4) begin n_fail++; $display("FAIL pb_count got %0d exp 4", k); end
`endif
        pb_mode = 2'b00;
    endtask

    initial begin
        test_reset();
        test_capture_freeze();
        test_read_latency();
        test_wrap();
        test_axi_write();
        test_same_cycle_and_reset();
        test_playback();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
